// File: rtl/alu_pkg.sv
// Shared ALU control encodings for the issue stage and its decoder.
// Used by alu_ctrl_dec (decode) and alu_issue_stage (top).
package alu_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'h0,
    ALU_OR  = 4'h1,
    ALU_ADD = 4'h2,
    ALU_SUB = 4'h6,
    ALU_NOR = 4'h7,
    ALU_ILL = 4'hF
  } alu_ctrl_e;

  typedef enum logic [1:0] {
    ALUOP_MEM = 2'b00,
    ALUOP_BR  = 2'b01,
    ALUOP_R   = 2'b10,
    ALUOP_I   = 2'b11
  } aluop_e;

  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_OR  = 3'b110;

endpackage

// File: rtl/alu_ctrl_dec.sv
// Combinational decode of {aluop, funct3, funct7[5]} into the 4-bit ALU control code.
// Unsupported funct3 values for R/I-type ops yield ALU_ILL and raise illegal.
module alu_ctrl_dec
  import alu_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [2:0] funct3,
  input  logic       f7b5,
  output logic [3:0] alu_ctrl,
  output logic       illegal
);

  always_comb begin
    alu_ctrl = ALU_ADD;
    illegal  = 1'b0;
    case (aluop)
      ALUOP_MEM: alu_ctrl = ALU_ADD;
      ALUOP_BR:  alu_ctrl = ALU_SUB;
      default: begin
        // f7b5 selects SUB only for R-type; for I-type it is part of the immediate
        case (funct3)
          F3_ADD:  alu_ctrl = ((aluop == ALUOP_R) && f7b5) ? ALU_SUB : ALU_ADD;
          F3_AND:  alu_ctrl = ALU_AND;
          F3_OR:   alu_ctrl = ALU_OR;
          default: begin
            alu_ctrl = ALU_ILL;
            illegal  = 1'b1;
          end
        endcase
      end
    endcase
  end

endmodule

// File: rtl/alu_issue_stage.sv
// ALU issue stage: decode, operand-b select and a 2-entry (main + skid) valid/ready buffer.
// Optional feature macro FORWARD_EN adds writeback forwarding into captured and held operands.
module alu_issue_stage
  import alu_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [1:0]      in_aluop,
  input  logic [2:0]      in_funct3,
  input  logic            in_f7b5,
  input  logic            in_alusrc,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_imm,
`ifdef FORWARD_EN
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic            wb_en,
  input  logic [4:0]      wb_rd,
  input  logic [XLEN-1:0] wb_data,
`endif
  output logic            out_valid,
  input  logic            out_ready,
  output logic [3:0]      alu_ctrl,
  output logic [XLEN-1:0] a,
  output logic [XLEN-1:0] b,
  output logic            illegal
);

  typedef struct packed {
    logic [3:0]      ctrl;
    logic            ill;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
`ifdef FORWARD_EN
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic            use_rs2;
`endif
  } entry_t;

  logic       dec_ill;
  logic [3:0] dec_ctrl;
  logic       skid_valid;
  logic       accept;
  logic       main_load;
  entry_t     main_q, skid_q;
  entry_t     in_raw, in_fwd, main_hold, skid_fwd;

  alu_ctrl_dec u_dec (
    .aluop    (in_aluop),
    .funct3   (in_funct3),
    .f7b5     (in_f7b5),
    .alu_ctrl (dec_ctrl),
    .illegal  (dec_ill)
  );

  always_comb begin
    in_raw      = '0;
    in_raw.ctrl = dec_ctrl;
    in_raw.ill  = dec_ill;
    in_raw.a    = in_rs1;
    in_raw.b    = in_alusrc ? in_imm : in_rs2;
`ifdef FORWARD_EN
    in_raw.rs1_addr = in_rs1_addr;
    in_raw.rs2_addr = in_rs2_addr;
    in_raw.use_rs2  = !in_alusrc;
`endif
  end

`ifdef FORWARD_EN
  // x0 never forwards; b only takes writeback data when it came from rs2
  function automatic entry_t fwd(entry_t e, logic en, logic [4:0] rd, logic [XLEN-1:0] d);
    entry_t r;
    r = e;
    if (en && (rd != 5'd0) && (rd == e.rs1_addr)) r.a = d;
    if (en && (rd != 5'd0) && e.use_rs2 && (rd == e.rs2_addr)) r.b = d;
    return r;
  endfunction

  assign in_fwd    = fwd(in_raw, wb_en, wb_rd, wb_data);
  assign main_hold = fwd(main_q, wb_en, wb_rd, wb_data);
  assign skid_fwd  = fwd(skid_q, wb_en, wb_rd, wb_data);
`else
  assign in_fwd    = in_raw;
  assign main_hold = main_q;
  assign skid_fwd  = skid_q;
`endif

  assign in_ready  = !skid_valid;
  assign accept    = in_valid && in_ready;
  assign main_load = !out_valid || out_ready;

  // Main refills from skid first to keep order; skid only catches an accept main cannot take
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      main_q     <= '0;
      skid_q     <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else begin
      if (main_load) begin
        out_valid <= skid_valid || accept;
        if (skid_valid)  main_q <= skid_fwd;
        else if (accept) main_q <= in_fwd;
        else             main_q <= main_hold;
      end else begin
        main_q <= main_hold;
      end

      if (skid_valid) begin
        skid_q <= skid_fwd;
        if (main_load) skid_valid <= 1'b0;
      end else if (accept && !main_load) begin
        skid_valid <= 1'b1;
        skid_q     <= in_fwd;
      end
    end
  end

  assign alu_ctrl = main_q.ctrl;
  assign illegal  = main_q.ill;
  assign a        = main_q.a;
  assign b        = main_q.b;

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed self-checking bench for alu_issue_stage: reset, decode, streaming, stall/flush
// and (when FORWARD_EN is defined) writeback forwarding.
module tb_alu_issue_stage;

  localparam int XLEN = 64;

  logic            clk, rst_n, flush;
  logic            in_valid, in_ready;
  logic [1:0]      in_aluop;
  logic [2:0]      in_funct3;
  logic            in_f7b5, in_alusrc;
  logic [XLEN-1:0] in_rs1, in_rs2, in_imm;
`ifdef FORWARD_EN
  logic [4:0]      in_rs1_addr, in_rs2_addr, wb_rd;
  logic            wb_en;
  logic [XLEN-1:0] wb_data;
`endif
  logic            out_valid, out_ready;
  logic [3:0]      alu_ctrl;
  logic [XLEN-1:0] alu_a, alu_b;
  logic            illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_issue_stage #(.XLEN(XLEN)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_aluop  (in_aluop),
    .in_funct3 (in_funct3),
    .in_f7b5   (in_f7b5),
    .in_alusrc (in_alusrc),
    .in_rs1    (in_rs1),
    .in_rs2    (in_rs2),
    .in_imm    (in_imm),
`ifdef FORWARD_EN
    .in_rs1_addr (in_rs1_addr),
    .in_rs2_addr (in_rs2_addr),
    .wb_en       (wb_en),
    .wb_rd       (wb_rd),
    .wb_data     (wb_data),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_ctrl  (alu_ctrl),
    .a         (alu_a),
    .b         (alu_b),
    .illegal   (illegal)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // Reference decode written from the encoding table: returns {ctrl, illegal}
  function automatic logic [4:0] model_dec(logic [1:0] op, logic [2:0] f3, logic f7);
    if (op == 2'b00) return {4'h2, 1'b0};
    if (op == 2'b01) return {4'h6, 1'b0};
    case (f3)
      3'b000:  return {((op == 2'b10) && f7) ? 4'h6 : 4'h2, 1'b0};
      3'b111:  return {4'h0, 1'b0};
      3'b110:  return {4'h1, 1'b0};
      default: return {4'hF, 1'b1};
    endcase
  endfunction

  task automatic applyStimulus(input logic [1:0] op, input logic [2:0] f3, input logic f7,
                               input logic src, input logic [XLEN-1:0] rs1,
                               input logic [XLEN-1:0] rs2, input logic [XLEN-1:0] imm);
    in_aluop  = op;
    in_funct3 = f3;
    in_f7b5   = f7;
    in_alusrc = src;
    in_rs1    = rs1;
    in_rs2    = rs2;
    in_imm    = imm;
  endtask

  task automatic go_idle();
    in_valid  = 1'b0;
    out_ready = 1'b1;
    flush     = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, alu_ctrl, alu_a, alu_b, illegal} !== {1'b0, 1'b1, 4'h0, 128'h0, 1'b0}) begin
      tests_failed++;
      $display("[TB] FAIL reset_initial: got v=%b r=%b ctrl=%h a=%h b=%h ill=%b",
               out_valid, in_ready, alu_ctrl, alu_a, alu_b, illegal);
    end
    rst_n = 1'b1;
    @(negedge clk);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    applyStimulus(2'b10, 3'b001, 1'b0, 1'b0, 64'h33, 64'h44, 64'h0);
    @(negedge clk);
    in_rs1 = 64'h34;
    @(negedge clk);
    in_valid = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b10) begin
      tests_failed++;
      $display("[TB] FAIL reset_prefill: got v=%b r=%b expected v=1 r=0", out_valid, in_ready);
    end
    #2 rst_n = 1'b0;
    #1;
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    tests_run++;
    if (in_ready !== 1'b1) begin
      tests_failed++;
      $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    tests_run++;
    if ({alu_ctrl, illegal, alu_a, alu_b} !== '0) begin
      tests_failed++;
      $display("[TB] FAIL reset_data: got ctrl=%h ill=%b a=%h b=%h expected all 0",
               alu_ctrl, illegal, alu_a, alu_b);
    end
    @(negedge clk);
    rst_n = 1'b1;
    go_idle();
  endtask

  typedef struct packed {
    logic [1:0] op;
    logic [2:0] f3;
    logic       f7;
    logic       src;
    logic [3:0] ctrl;
    logic       ill;
  } dvec_t;

  task automatic test_decode();
    dvec_t dv[11];
    logic [XLEN-1:0] rs1, rs2, imm, exp_b;
    dv[0]  = '{2'b10, 3'b000, 1'b1, 1'b0, 4'h6, 1'b0};
    dv[1]  = '{2'b11, 3'b000, 1'b1, 1'b1, 4'h2, 1'b0};
    dv[2]  = '{2'b10, 3'b000, 1'b0, 1'b0, 4'h2, 1'b0};
    dv[3]  = '{2'b10, 3'b111, 1'b0, 1'b0, 4'h0, 1'b0};
    dv[4]  = '{2'b10, 3'b110, 1'b1, 1'b0, 4'h1, 1'b0};
    dv[5]  = '{2'b11, 3'b111, 1'b0, 1'b1, 4'h0, 1'b0};
    dv[6]  = '{2'b11, 3'b110, 1'b0, 1'b0, 4'h1, 1'b0};
    dv[7]  = '{2'b10, 3'b001, 1'b0, 1'b0, 4'hF, 1'b1};
    dv[8]  = '{2'b11, 3'b101, 1'b1, 1'b1, 4'hF, 1'b1};
    dv[9]  = '{2'b00, 3'b101, 1'b1, 1'b1, 4'h2, 1'b0};
    dv[10] = '{2'b01, 3'b011, 1'b0, 1'b0, 4'h6, 1'b0};
    for (int i = 0; i < 11; i++) begin
      rs1   = (i == 0) ? 64'd10 : 64'h1000 + 64'(i);
      rs2   = (i == 0) ? 64'd3  : 64'h2000 + 64'(i);
      imm   = 64'hFFFF_FFFF_FFFF_FFFF;
      exp_b = dv[i].src ? imm : rs2;
      @(negedge clk);
      applyStimulus(dv[i].op, dv[i].f3, dv[i].f7, dv[i].src, rs1, rs2, imm);
      in_valid  = 1'b1;
      out_ready = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      tests_run++;
      if (out_valid !== 1'b1) begin
        tests_failed++;
        $display("[TB] FAIL decode%0d_valid: got %b expected 1", i, out_valid);
      end
      tests_run++;
      if (alu_ctrl !== dv[i].ctrl) begin
        tests_failed++;
        $display("[TB] FAIL decode%0d_ctrl: got %h expected %h", i, alu_ctrl, dv[i].ctrl);
      end
      tests_run++;
      if (illegal !== dv[i].ill) begin
        tests_failed++;
        $display("[TB] FAIL decode%0d_illegal: got %b expected %b", i, illegal, dv[i].ill);
      end
      tests_run++;
      if (alu_a !== rs1) begin
        tests_failed++;
        $display("[TB] FAIL decode%0d_a: got %h expected %h", i, alu_a, rs1);
      end
      tests_run++;
      if (alu_b !== exp_b) begin
        tests_failed++;
        $display("[TB] FAIL decode%0d_b: got %h expected %h", i, alu_b, exp_b);
      end
    end
    go_idle();
  endtask

  task automatic test_stream();
    logic [132:0] exp_q[$];
    logic [132:0] exp_v;
    logic [4:0]   d;
    logic         acc, fire, acc_prev;
    int           sent, got, cycles;
    sent = 0; got = 0; cycles = 0; acc_prev = 1'b1;
    while ((got < 1000) && (cycles < 20000)) begin
      @(negedge clk);
      cycles++;
      if (acc_prev)
        applyStimulus(2'($urandom), 3'($urandom), 1'($urandom), 1'($urandom),
                      {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom});
      in_valid  = (sent < 1000);
      out_ready = 1'($urandom_range(0, 1));
      fire = out_valid && out_ready;
      acc  = in_valid && in_ready;
      if (fire) begin
        tests_run++;
        if (exp_q.size() == 0) begin
          tests_failed++;
          $display("[TB] FAIL stream_extra: output %h with nothing expected", alu_a);
        end else begin
          exp_v = exp_q.pop_front();
          if ({alu_ctrl, illegal, alu_a, alu_b} !== exp_v) begin
            tests_failed++;
            $display("[TB] FAIL stream_op%0d: got %h expected %h", got,
                     {alu_ctrl, illegal, alu_a, alu_b}, exp_v);
          end
        end
        got++;
      end
      if (acc) begin
        d = model_dec(in_aluop, in_funct3, in_f7b5);
        exp_q.push_back({d, in_rs1, in_alusrc ? in_imm : in_rs2});
        sent++;
      end
      acc_prev = acc;
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if (got !== 1000) begin
      tests_failed++;
      $display("[TB] FAIL stream_count: got %0d ops expected 1000 within cycle budget", got);
    end
    @(negedge clk);
    tests_run++;
    if (out_valid !== 1'b0) begin
      tests_failed++;
      $display("[TB] FAIL stream_drained: out_valid got %b expected 0", out_valid);
    end
    go_idle();
  endtask

  task automatic test_back_to_back();
    applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
    out_ready = 1'b1;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (k > 0) begin
        tests_run++;
        if ({out_valid, in_ready, alu_a} !== {1'b1, 1'b1, 64'(k - 1)}) begin
          tests_failed++;
          $display("[TB] FAIL b2b_cycle%0d: got v=%b r=%b a=%h expected v=1 r=1 a=%h",
                   k, out_valid, in_ready, alu_a, 64'(k - 1));
        end
      end
      in_valid = 1'b1;
      in_rs1   = 64'(k);
    end
    in_valid = 1'b0;
    go_idle();
  endtask

  task automatic test_stall_flush();
    applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 64'h100, 64'h0, 64'h0);
    in_valid  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, alu_a} !== {1'b1, 1'b1, 64'h100}) begin
      tests_failed++;
      $display("[TB] FAIL stall_first: got v=%b r=%b a=%h expected v=1 r=1 a=100",
               out_valid, in_ready, alu_a);
    end
    in_rs1 = 64'h101;
    @(negedge clk);
    tests_run++;
    if ({in_ready, alu_a} !== {1'b0, 64'h100}) begin
      tests_failed++;
      $display("[TB] FAIL stall_skid_full: got r=%b a=%h expected r=0 a=100", in_ready, alu_a);
    end
    in_rs1 = 64'h102;
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, alu_a} !== {1'b1, 1'b0, 64'h100}) begin
      tests_failed++;
      $display("[TB] FAIL stall_hold: got v=%b r=%b a=%h expected v=1 r=0 a=100",
               out_valid, in_ready, alu_a);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({out_valid, in_ready, alu_a} !== {1'b1, 1'b1, 64'h101}) begin
      tests_failed++;
      $display("[TB] FAIL stall_drain: got v=%b r=%b a=%h expected v=1 r=1 a=101",
               out_valid, in_ready, alu_a);
    end
    out_ready = 1'b0;
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_rs1    = 64'h104;
    @(negedge clk);
    flush     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL flush_clear: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      tests_run++;
      if (out_valid !== 1'b0) begin
        tests_failed++;
        $display("[TB] FAIL flush_discard%0d: out_valid got %b expected 0 (a=%h)", k, out_valid, alu_a);
      end
    end
    in_valid  = 1'b1;
    out_ready = 1'b0;
    in_rs1    = 64'h200;
    @(negedge clk);
    in_rs1 = 64'h201;
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    tests_run++;
    if ({out_valid, in_ready} !== 2'b01) begin
      tests_failed++;
      $display("[TB] FAIL flush_full: got v=%b r=%b expected v=0 r=1", out_valid, in_ready);
    end
    go_idle();
  endtask

`ifdef FORWARD_EN
  task automatic test_forward();
    out_ready = 1'b0;
    applyStimulus(2'b10, 3'b000, 1'b0, 1'b0, 64'h11, 64'h12, 64'h0);
    in_rs1_addr = 5'd5; in_rs2_addr = 5'd6;
    wb_en = 1'b1; wb_rd = 5'd5; wb_data = 64'h55;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; wb_en = 1'b0;
    tests_run++;
    if ({alu_a, alu_b} !== {64'h55, 64'h12}) begin
      tests_failed++;
      $display("[TB] FAIL fwd_capture: got a=%h b=%h expected a=55 b=12", alu_a, alu_b);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_rs1 = 64'h22; in_rs1_addr = 5'd0;
    wb_en = 1'b1; wb_rd = 5'd0; wb_data = 64'h66;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0; wb_en = 1'b0;
    tests_run++;
    if (alu_a !== 64'h22) begin
      tests_failed++;
      $display("[TB] FAIL fwd_x0: got a=%h expected 22", alu_a);
    end
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    in_rs1 = 64'hA; in_rs1_addr = 5'd1; in_rs2_addr = 5'd2;
    in_valid = 1'b1;
    @(negedge clk);
    in_rs1 = 64'hB; in_rs2 = 64'hC; in_rs1_addr = 5'd7; in_rs2_addr = 5'd8;
    @(negedge clk);
    in_valid = 1'b0;
    wb_en = 1'b1; wb_rd = 5'd7; wb_data = 64'h77;
    @(negedge clk);
    wb_rd = 5'd8; wb_data = 64'h88;
    @(negedge clk);
    wb_en = 1'b0;
    tests_run++;
    if (alu_a !== 64'hA) begin
      tests_failed++;
      $display("[TB] FAIL fwd_main_untouched: got a=%h expected a", alu_a);
    end
    out_ready = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({out_valid, alu_a, alu_b} !== {1'b1, 64'h77, 64'h88}) begin
      tests_failed++;
      $display("[TB] FAIL fwd_skid: got v=%b a=%h b=%h expected v=1 a=77 b=88",
               out_valid, alu_a, alu_b);
    end
    go_idle();
  endtask
`endif

  initial begin
    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    applyStimulus(2'b00, 3'b000, 1'b0, 1'b0, 64'h0, 64'h0, 64'h0);
`ifdef FORWARD_EN
    in_rs1_addr = 5'd0; in_rs2_addr = 5'd0; wb_en = 1'b0; wb_rd = 5'd0; wb_data = '0;
`endif
    test_reset();
    test_decode();
    test_back_to_back();
    test_stall_flush();
    test_stream();
`ifdef FORWARD_EN
    test_forward();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
